// File: rtl/dpll_pkg.sv
// Shared constants for the DPLL lock controller: state encoding, loop defaults
// and a helper that turns a signed phase error into a saturated magnitude.
package dpll_pkg;

  localparam int PHASE_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_ACQ   = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  localparam logic [PHASE_W-1:0] FREQ_INIT_DEF = 16'h0400;
  localparam logic [PHASE_W-1:0] STEP_MIN_DEF  = 16'h0040;
  localparam logic [PHASE_W-1:0] STEP_MAX_DEF  = 16'h4000;

  // The most negative error has no positive twin, so its magnitude pins at 32767.
  function automatic logic [PHASE_W-1:0] abs_sat(input logic signed [PHASE_W-1:0] e);
    if (e == 16'sh8000)  return 16'h7FFF;
    else if (e < 0)      return PHASE_W'(-e);
    else                 return PHASE_W'(e);
  endfunction

endpackage

// File: rtl/dpll_lock_ctrl_if.sv
// Loop-side signals of the DPLL lock controller: reference and NCO phase in,
// NCO increment, accumulator clear and lock status out.
interface dpll_lock_ctrl_if;
  logic                         en;
  logic                         in;
  logic [dpll_pkg::PHASE_W-1:0] phase;
  logic [dpll_pkg::PHASE_W-1:0] step;
  logic                         nco_clr;
  logic                         locked;
  logic [1:0]                   state;

  modport master (output en, in, phase, input step, nco_clr, locked, state);
  modport slave  (input en, in, phase, output step, nco_clr, locked, state);
endinterface

// File: rtl/dpll_step_upd.sv
// Combinational loop filter: subtract the gain-scaled phase error from the
// current increment and clamp the result into the legal NCO range.
module dpll_step_upd
  import dpll_pkg::*;
#(
  parameter logic [PHASE_W-1:0] STEP_MIN = STEP_MIN_DEF,
  parameter logic [PHASE_W-1:0] STEP_MAX = STEP_MAX_DEF
) (
  input  logic        [PHASE_W-1:0] step,
  input  logic signed [PHASE_W-1:0] err,
  input  logic        [3:0]         shift,
  output logic        [PHASE_W-1:0] step_next
);

  logic signed [PHASE_W-1:0] corr;
  logic signed [PHASE_W:0]   diff;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    corr      = err >>> shift;
    diff      = $signed({1'b0, step}) - $signed({corr[PHASE_W-1], corr});
    step_next = diff[PHASE_W-1:0];
    if (diff < $signed({1'b0, STEP_MIN}))      step_next = STEP_MIN;
    else if (diff > $signed({1'b0, STEP_MAX})) step_next = STEP_MAX;
  end

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL lock controller: aligns the NCO to the first reference edge, then runs a
// two-gain loop (acquire / track) with lock qualification and edge-loss timeout.
module dpll_lock_ctrl
  import dpll_pkg::*;
#(
  parameter logic [PHASE_W-1:0] FREQ_INIT  = FREQ_INIT_DEF,
  parameter logic [PHASE_W-1:0] STEP_MIN   = STEP_MIN_DEF,
  parameter logic [PHASE_W-1:0] STEP_MAX   = STEP_MAX_DEF,
  parameter int                 KA_SHIFT   = 4,
  parameter int                 KT_SHIFT   = 8,
  parameter logic [PHASE_W-1:0] LOCK_THR   = 16'd512,
  parameter logic [PHASE_W-1:0] UNLOCK_THR = 16'd4096,
  parameter int                 LOCK_CNT   = 8,
  parameter logic [15:0]        TIMEOUT    = 16'hFFFF
) (
  input logic               clk,
  input logic               rst,
  dpll_lock_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  logic [1:0]               state;
  logic                     in_d;
  logic [PHASE_W-1:0]       step;
  logic                     nco_clr;
  logic                     locked;
  logic [CNT_W-1:0]         good_cnt;
  logic [15:0]              tmo_cnt;

  logic                     ref_edge;
  logic signed [PHASE_W-1:0] err;
  logic [PHASE_W-1:0]       err_mag;
  logic [PHASE_W-1:0]       step_next;
  logic [CNT_W-1:0]         good_inc;
  logic [3:0]               shift;

  always_comb begin
    ref_edge = bus.in & ~in_d;
    err      = $signed(bus.phase);
    err_mag  = abs_sat(err);
    shift    = (state == ST_LOCK) ? 4'(KT_SHIFT) : 4'(KA_SHIFT);
    good_inc = (good_cnt == CNT_W'(LOCK_CNT)) ? good_cnt : good_cnt + 1'b1;
  end

  dpll_step_upd #(
    .STEP_MIN (STEP_MIN),
    .STEP_MAX (STEP_MAX)
  ) u_step_upd (
    .step      (step),
    .err       (err),
    .shift     (shift),
    .step_next (step_next)
  );

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      in_d     <= 1'b0;
      step     <= FREQ_INIT;
      nco_clr  <= 1'b0;
      locked   <= 1'b0;
      good_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      in_d    <= bus.in;
      nco_clr <= 1'b0;
      if (!bus.en) begin
        // Disable outranks any edge, timeout or lock decision in the same cycle.
        state    <= ST_IDLE;
        step     <= FREQ_INIT;
        locked   <= 1'b0;
        good_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            step    <= FREQ_INIT;
            tmo_cnt <= '0;
            state   <= ST_ALIGN;
          end
          ST_ALIGN: begin
            if (ref_edge) begin
              nco_clr  <= 1'b1;
              good_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= ST_ACQ;
            end else if (tmo_cnt != TIMEOUT) begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          ST_ACQ: begin
            if (ref_edge) begin
              step    <= step_next;
              tmo_cnt <= '0;
              if (err_mag < LOCK_THR) begin
                good_cnt <= good_inc;
                if (good_inc == CNT_W'(LOCK_CNT)) begin
                  state  <= ST_LOCK;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end else if (tmo_cnt == TIMEOUT) begin
              state   <= ST_ALIGN;
              locked  <= 1'b0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: begin // ST_LOCK
            if (ref_edge) begin
              step    <= step_next;
              tmo_cnt <= '0;
              if (err_mag >= UNLOCK_THR) begin
                state    <= ST_ACQ;
                locked   <= 1'b0;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_inc;
              end
            end else if (tmo_cnt == TIMEOUT) begin
              state   <= ST_ALIGN;
              locked  <= 1'b0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.state   = state;
  assign bus.step    = step;
  assign bus.nco_clr = nco_clr;
  assign bus.locked  = locked;

endmodule

// File: doc/dpll_lock_ctrl.md
DPLL_LOCK_CTRL -- requirements
Module: dpll_lock_ctrl

Interface
REQ-001 Parameter FREQ_INIT, 16'h0400, NCO phase increment loaded at reset and in IDLE.
REQ-002 Parameter STEP_MIN / STEP_MAX, 16'h0040 / 16'h4000, saturation bounds for step.
REQ-003 Parameter KA_SHIFT, 4, acquisition gain as an arithmetic right shift of the error.
REQ-004 Parameter KT_SHIFT, 8, tracking gain as an arithmetic right shift of the error.
REQ-005 Parameter LOCK_THR, 16'd512, |err| below this counts as a good edge.
REQ-006 Parameter UNLOCK_THR, 16'd4096, |err| at or above this in LOCK causes loss of lock.
REQ-007 Parameter LOCK_CNT, 8, number of consecutive good edges required to declare lock.
REQ-008 Parameter TIMEOUT, 16'hFFFF, clk cycles without a reference edge before realignment.
REQ-009 clk  in  1  single system clock; all state changes on its rising edge.
REQ-010 rst  in  1  reset, asynchronous assert, active-low.
REQ-011 en  in  1  loop enable; 0 forces IDLE.
REQ-012 in  in  1  reference input, already synchronised to clk.
REQ-013 phase  in  16  NCO phase-accumulator value, read as signed error at reference edges.
REQ-014 step  out  16  registered NCO phase increment.
REQ-015 nco_clr  out  1  registered one-cycle pulse that clears the NCO accumulator.
REQ-016 locked  out  1  registered lock indication.
REQ-017 state  out  2  current FSM state: IDLE=0, ALIGN=1, ACQ=2, LOCK=3.

Function
REQ-018 Edge detect: a register in_d holds the previous value of in; edge = in & ~in_d, evaluated at each rising clk edge.
REQ-019 Error: err = signed(phase) sampled at the clk edge where edge=1; |err| of -32768 saturates to 32767.
REQ-020 Step update: step <= sat(step - (err >>> K)), with a 17-bit signed intermediate, clamped to [STEP_MIN, STEP_MAX]; new value visible one clk after the edge.
REQ-021 IDLE: step=FREQ_INIT, nco_clr=0, locked=0; en=1 -> ALIGN.
REQ-022 ALIGN: step held; first edge -> nco_clr=1 for exactly one cycle, good counter=0, -> ACQ; no step update on this edge.
REQ-023 ACQ: each edge applies REQ-020 with K=KA_SHIFT; |err|<LOCK_THR increments the good counter, else clears it; the edge making the counter equal LOCK_CNT -> LOCK and sets locked=1 on the next cycle.
REQ-024 LOCK: each edge applies REQ-020 with K=KT_SHIFT; |err|>=UNLOCK_THR -> ACQ, locked=0, good counter=0; this step update still applies.
REQ-025 Timeout: the cycle counter clears on every edge and on state entry; reaching TIMEOUT in ACQ or LOCK -> ALIGN, locked=0, step held.
REQ-026 en=0 in any state -> IDLE on the next clk; this has priority over edge, timeout and lock transitions in the same cycle.
REQ-027 An edge coinciding with a timeout: the edge wins and the counter clears.
REQ-028 Good counter saturates at LOCK_CNT; the timeout counter saturates at TIMEOUT.

Reset
REQ-029 rst=0 asynchronously forces IDLE: step=FREQ_INIT, nco_clr=0, locked=0, state=0, in_d=0, counters=0.
REQ-030 Reset release is synchronous to clk; the first state change occurs no earlier than the first clk edge after rst=1.
REQ-031 Reset mid-operation (any state) discards all loop history.

Structure
REQ-032 Shared package dpll_pkg holds the state enumeration, FREQ_INIT, STEP_MIN/STEP_MAX, and the phase width (16).
REQ-033 One sub-module, dpll_step_upd: combinational shift, subtract and saturate (REQ-020); the FSM and counters stay in dpll_lock_ctrl.

Verification
REQ-034 Reset: rst=0 for 3 clk, then en=1 -> state=0 until release; step=16'h0400, locked=0, nco_clr=0.
REQ-035 Align: en=1 and first in rise -> nco_clr high for exactly one cycle; state 1 -> 2; step unchanged.
REQ-036 Acquire: phase=16'h0100 on edges -> step decreases by 16 per edge; after 8 consecutive edges with |err|<512, locked=1 and state=3.
REQ-037 Saturation: phase=16'h8000 on repeated ACQ edges -> step clamps at 16'h4000 with no wrap; phase=16'h7FFF -> step clamps at 16'h0040.
REQ-038 Loss of lock: in LOCK, one edge with phase=16'h1000 -> locked=0 and state=2 next cycle; 70000 cycles with no edge -> state=1.
REQ-039 Priority: en=0 in the same cycle as the 8th good edge -> state=0, locked stays 0, step=16'h0400.
